serdesphy_cdr_loop_filter: RTL and testbench

SERDESPHY_CDR_LOOP_FILTER -- requirements
Module: serdesphy_cdr_loop_filter

---
 rtl/serdesphy_cdr_loop_filter.sv | 235 +++++++++++++++++++++++
 tb/tb_serdesphy_cdr_loop_filter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serdesphy_cdr_loop_filter.sv
// -----------------------------------------------------------------------------
// serdesphy_cdr_loop_filter
//
// Second-order bang-bang CDR loop filter. Early/late votes from the phase
// detector drive a saturating 12-bit integrator (frequency path) and a
// one-cycle proportional kick (phase path). Their sum becomes the 8-bit VCO
// control word. A small state machine handles the following:
//   - It holds the loop at its home value while disabled.
//   - It runs a fast acquisition phase with a large integrator step.
//   - It then tracks with a small step.
//   - It declares lock when a window of votes is balanced and the integrator
//     is not pinned at a rail.
//
// Ports
//   clk          single block clock, rising edge
//   rst          synchronous active-high reset
//   enable       loop enable
//   vco_ready    VCO stable flag
//   pd_valid     phase-detector sample strobe (one per vote)
//   pd_early     clock-early vote, qualified by pd_valid
//   pd_late      clock-late vote, qualified by pd_valid
//   cdr_control  VCO control word, 128 = nominal
//   cdr_locked   high while in LOCKED
//   cdr_state    IDLE=0, ACQUIRE=1, TRACK=2, LOCKED=3
// -----------------------------------------------------------------------------
module serdesphy_cdr_loop_filter #(
    parameter int KP        = 2,
    parameter int KI_ACQ    = 4,
    parameter int KI_TRK    = 1,
    parameter int ACQ_VOTES = 64,
    parameter int LOCK_WIN  = 32,
    parameter int LOCK_TOL  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       vco_ready,
    input  logic       pd_valid,
    input  logic       pd_early,
    input  logic       pd_late,
    output logic [7:0] cdr_control,
    output logic       cdr_locked,
    output logic [1:0] cdr_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    localparam int AW = $clog2(ACQ_VOTES + 1);
    localparam int WW = $clog2(LOCK_WIN + 1);
    // The imbalance spans -LOCK_WIN..+LOCK_WIN, so it needs one extra bit
    // for sign and one for headroom.
    localparam int IW = $clog2(LOCK_WIN + 1) + 2;

    localparam logic [11:0]          INTEG_HOME = 12'h800;
    localparam logic signed [8:0]    KP_S       = 9'(KP);
    localparam logic [11:0]          KI_ACQ_V   = 12'(KI_ACQ);
    localparam logic [11:0]          KI_TRK_V   = 12'(KI_TRK);
    localparam logic [AW-1:0]        ACQ_LAST   = AW'(ACQ_VOTES - 1);
    localparam logic [WW-1:0]        WIN_LAST   = WW'(LOCK_WIN - 1);
    localparam logic signed [IW-1:0] TOL_S      = IW'(LOCK_TOL);

    state_t                 state_reg, state_next;
    logic [11:0]            integ_reg, integ_next;
    logic signed [8:0]      p_reg, p_next;
    logic [AW-1:0]          acq_cnt_reg, acq_cnt_next;
    logic [WW-1:0]          win_cnt_reg, win_cnt_next;
    logic signed [IW-1:0]   imb_reg, imb_next;

    logic                   run_ok;
    logic                   vote_late;
    logic                   vote_early;
    logic [11:0]            ki_val;
    logic signed [13:0]     integ_sum;
    logic [11:0]            integ_upd;
    logic signed [IW-1:0]   imb_delta;
    logic signed [IW-1:0]   imb_upd;
    logic signed [IW-1:0]   imb_abs;
    logic                   window_good;
    logic signed [9:0]      ctrl_sum;

    assign run_ok     = enable & vco_ready;
    // A vote with both or neither flag set is a null sample: it is counted
    // but does not move the loop.
    assign vote_late  = pd_valid & pd_late & ~pd_early;
    assign vote_early = pd_valid & pd_early & ~pd_late;

    // ------------------------------------------------------------------
    // Saturating integrator update and lock-window evaluation
    // ------------------------------------------------------------------
    always_comb begin
        ki_val    = (state_reg == ST_ACQUIRE) ? KI_ACQ_V : KI_TRK_V;
        integ_sum = $signed({2'b00, integ_reg});
        if (vote_late) begin
            integ_sum = $signed({2'b00, integ_reg}) + $signed({2'b00, ki_val});
        end else if (vote_early) begin
            integ_sum = $signed({2'b00, integ_reg}) - $signed({2'b00, ki_val});
        end

        if (integ_sum < 14'sd0) begin
            integ_upd = 12'h000;
        end else if (integ_sum > 14'sd4095) begin
            integ_upd = 12'hFFF;
        end else begin
            integ_upd = integ_sum[11:0];
        end

        imb_delta = '0;
        if (vote_late) begin
            imb_delta = IW'(1);
        end else if (vote_early) begin
            imb_delta = '1;
        end
        imb_upd = imb_reg + imb_delta;
        imb_abs = (imb_upd < 0) ? -imb_upd : imb_upd;

        // A window pinned against a rail is never trusted as lock, even if
        // the votes happen to be balanced.
        window_good = (imb_abs <= TOL_S) &&
                      (integ_upd != 12'h000) && (integ_upd != 12'hFFF);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        integ_next   = integ_reg;
        p_next       = '0;
        acq_cnt_next = acq_cnt_reg;
        win_cnt_next = win_cnt_reg;
        imb_next     = imb_reg;

        case (state_reg)
            ST_IDLE: begin
                integ_next   = INTEG_HOME;
                acq_cnt_next = '0;
                win_cnt_next = '0;
                imb_next     = '0;
                if (run_ok) begin
                    state_next = ST_ACQUIRE;
                end
            end

            default: begin
                if (!run_ok) begin
                    // Dropping out discards any vote on this cycle.
                    state_next   = ST_IDLE;
                    integ_next   = INTEG_HOME;
                    acq_cnt_next = '0;
                    win_cnt_next = '0;
                    imb_next     = '0;
                end else begin
                    integ_next = integ_upd;
                    if (vote_late) begin
                        p_next = KP_S;
                    end else if (vote_early) begin
                        p_next = -KP_S;
                    end

                    if (state_reg == ST_ACQUIRE) begin
                        if (pd_valid) begin
                            if (acq_cnt_reg == ACQ_LAST) begin
                                state_next   = ST_TRACK;
                                acq_cnt_next = '0;
                            end else begin
                                acq_cnt_next = acq_cnt_reg + AW'(1);
                            end
                        end
                    end else begin
                        acq_cnt_next = '0;
                        if (pd_valid) begin
                            if (win_cnt_reg == WIN_LAST) begin
                                win_cnt_next = '0;
                                imb_next     = '0;
                                if (state_reg == ST_TRACK && window_good) begin
                                    state_next = ST_LOCKED;
                                end else if (state_reg == ST_LOCKED && !window_good) begin
                                    state_next = ST_TRACK;
                                end
                            end else begin
                                win_cnt_next = win_cnt_reg + WW'(1);
                                imb_next     = imb_upd;
                            end
                        end
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            integ_reg   <= INTEG_HOME;
            p_reg       <= '0;
            acq_cnt_reg <= '0;
            win_cnt_reg <= '0;
            imb_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            integ_reg   <= integ_next;
            p_reg       <= p_next;
            acq_cnt_reg <= acq_cnt_next;
            win_cnt_reg <= win_cnt_next;
            imb_reg     <= imb_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: purely from registers, so a vote shows up right after the
    // edge that consumed it.
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_sum = $signed({2'b00, integ_reg[11:4]}) + $signed({p_reg[8], p_reg});
        if (ctrl_sum < 10'sd0) begin
            cdr_control = 8'd0;
        end else if (ctrl_sum > 10'sd255) begin
            cdr_control = 8'd255;
        end else begin
            cdr_control = ctrl_sum[7:0];
        end
    end

    assign cdr_locked = (state_reg == ST_LOCKED);
    assign cdr_state  = state_reg;

endmodule

// File: tb/tb_serdesphy_cdr_loop_filter.sv
// -----------------------------------------------------------------------------
// Testbench for serdesphy_cdr_loop_filter.
// A stimulus process drives one cycle at a time and queues the outputs that
// are expected after the next rising edge. A monitor process on the falling
// edge pops the due entries and compares them.
// -----------------------------------------------------------------------------
module tb_serdesphy_cdr_loop_filter;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       vco_ready;
    logic       pd_valid;
    logic       pd_early;
    logic       pd_late;
    logic [7:0] cdr_control;
    logic       cdr_locked;
    logic [1:0] cdr_state;

    always #5 clk = ~clk;

    serdesphy_cdr_loop_filter dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .vco_ready   (vco_ready),
        .pd_valid    (pd_valid),
        .pd_early    (pd_early),
        .pd_late     (pd_late),
        .cdr_control (cdr_control),
        .cdr_locked  (cdr_locked),
        .cdr_state   (cdr_state)
    );

    typedef struct {
        int    due;
        int    ctrl;
        int    st;
        int    lk;
        string name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   integ_m;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation that has come due.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (e.due != cyc ||
                cdr_control !== 8'(e.ctrl) ||
                cdr_state   !== 2'(e.st)   ||
                cdr_locked  !== 1'(e.lk)) begin
                errors++;
                $display("FAIL %s cyc=%0d control got %0d want %0d state got %0d want %0d locked got %0d want %0d",
                         e.name, cyc, cdr_control, e.ctrl, cdr_state, e.st, cdr_locked, e.lk);
            end
        end
    end

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic r, input logic en, input logic vr,
                        input logic pv, input logic pe, input logic pl,
                        input int ectrl, input int est, input int elk,
                        input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst       = r;
        enable    = en;
        vco_ready = vr;
        pd_valid  = pv;
        pd_early  = pe;
        pd_late   = pl;
        e.due  = cyc + 1;
        e.ctrl = ectrl;
        e.st   = est;
        e.lk   = elk;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Enable the loop, then issue 64 votes in one direction. In ACQUIRE each
    // vote moves integ by 4, and the last vote moves the state to TRACK.
    task automatic acquire(input logic late);
        step(0, 1, 1, 0, 0, 0, 128, 1, 0, "enable");
        for (int k = 1; k <= 64; k++) begin
            int ig;
            ig = late ? (2048 + 4 * k) : (2048 - 4 * k);
            step(0, 1, 1, 1, ~late, late, clamp((ig >> 4) + (late ? 2 : -2), 0, 255),
                 (k == 64) ? 2 : 1, 0, "acquire");
        end
        integ_m = late ? 2304 : 1792;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; vco_ready = 1'b1;
        pd_valid = 1'b1; pd_early = 1'b0; pd_late = 1'b1;

        // Reset wins over enable and votes.
        step(1, 1, 1, 1, 0, 1, 128, 0, 0, "reset0");
        step(1, 1, 1, 1, 0, 0, 128, 0, 0, "reset1");
        // A vote in IDLE is ignored.
        step(0, 0, 1, 1, 0, 1, 128, 0, 0, "idle_vote");

        // Acquisition: integ ends at 0x900, giving 146 with the kick and 144 without it.
        acquire(1'b1);
        step(0, 1, 1, 0, 0, 0, 144, 2, 0, "post_kick");
        // A null vote leaves the control unchanged but uses window sample 0.
        step(0, 1, 1, 1, 1, 1, 144, 2, 0, "null_vote");

        // Lock: 31 alternating votes complete the window (imbalance +1).
        for (int i = 0; i < 31; i++) begin
            logic late;
            late = (i % 2 == 0);
            integ_m += late ? 1 : -1;
            step(0, 1, 1, 1, ~late, late, (integ_m >> 4) + (late ? 2 : -2),
                 (i == 30) ? 3 : 2, (i == 30) ? 1 : 0, "lock");
        end

        // Unlock: a window of 32 late votes is unbalanced.
        for (int j = 1; j <= 32; j++) begin
            integ_m += 1;
            step(0, 1, 1, 1, 0, 1, (integ_m >> 4) + 2,
                 (j == 32) ? 2 : 3, (j == 32) ? 0 : 1, "unlock");
        end

        // Relock with a perfectly balanced window.
        for (int i = 0; i < 32; i++) begin
            logic late;
            late = (i % 2 == 1);
            integ_m += late ? 1 : -1;
            step(0, 1, 1, 1, ~late, late, (integ_m >> 4) + (late ? 2 : -2),
                 (i == 31) ? 3 : 2, (i == 31) ? 1 : 0, "relock");
        end

        // Disable while LOCKED: the loop drops home at once, and the vote is dropped too.
        step(0, 0, 1, 1, 0, 1, 128, 0, 0, "disable");
        step(0, 0, 1, 0, 0, 0, 128, 0, 0, "disabled_hold");

        // Upper saturation in TRACK.
        acquire(1'b1);
        for (int j = 1; j <= 1900; j++) begin
            integ_m = clamp(integ_m + 1, 0, 4095);
            step(0, 1, 1, 1, 0, 1, clamp((integ_m >> 4) + 2, 0, 255), 2, 0, "sat_high");
        end

        // Reset in the middle of operation.
        step(1, 1, 1, 1, 0, 1, 128, 0, 0, "mid_reset");

        // Lower saturation in TRACK.
        acquire(1'b0);
        for (int j = 1; j <= 1900; j++) begin
            integ_m = clamp(integ_m - 1, 0, 4095);
            step(0, 1, 1, 1, 1, 0, clamp((integ_m >> 4) - 2, 0, 255), 2, 0, "sat_low");
        end

        // Losing vco_ready also returns the loop to IDLE.
        step(0, 1, 0, 1, 1, 0, 128, 0, 0, "vco_drop");
        step(0, 0, 0, 0, 0, 0, 128, 0, 0, "final_idle");

        // Bounded drain of the scoreboard.
        for (int t = 0; t < 10 && sb.size() > 0; t++) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
